// File: rtl/acl_spi_responder_if.sv
// Pin and local-port bundle between the accel SPI responder and its peers.
// Signal names match the ACL_* nets of the accel SPI master.
interface acl_spi_responder_if #(
  parameter int ADDR_W = 6
);
  logic              ACL_CSN;
  logic              ACL_SCLK;
  logic              ACL_MOSI;
  logic              ACL_MISO;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [7:0]        loc_wdata;
  logic              spi_wr_valid;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic [7:0]        spi_wr_data;
  logic              txn_done;

  modport slave (
    input  ACL_CSN, ACL_SCLK, ACL_MOSI, loc_we, loc_addr, loc_wdata,
    output ACL_MISO, spi_wr_valid, spi_wr_addr, spi_wr_data, txn_done
  );

  modport master (
    output ACL_CSN, ACL_SCLK, ACL_MOSI, loc_we, loc_addr, loc_wdata,
    input  ACL_MISO, spi_wr_valid, spi_wr_addr, spi_wr_data, txn_done
  );
endinterface

// File: rtl/acl_spi_responder.sv
// Clocked SPI mode-0 slave modelling the accelerometer: 0x0A write / 0x0B read
// with burst auto-increment over a byte-wide register file plus a local port.
module acl_spi_responder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int RO_TOP = 4
) (
  input logic                 clk,
  input logic                 rst,
  acl_spi_responder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  // CSN stages reset low so a CSN already low when rst drops never yields a
  // fall strobe: the rest of that window is dropped until CSN rises.
  logic [2:0] csn_q, csn_d;
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] mosi_q, mosi_d;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shin_q, shin_d;
  logic [7:0]        shout_q, shout_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_flag_q, wr_flag_d;
  logic              seen_rise_q, seen_rise_d;
  logic              miso_q, miso_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic [7:0]        regs_q [DEPTH];
  logic [7:0]        regs_d [DEPTH];

  logic              csn_rise, csn_fall, sclk_rise, sclk_fall, byte_done;
  logic [7:0]        byte_next;
  logic [ADDR_W-1:0] ptr_inc, addr_byte;

  assign csn_d     = {csn_q[1:0], bus.ACL_CSN};
  assign sclk_d    = {sclk_q[1:0], bus.ACL_SCLK};
  assign mosi_d    = {mosi_q[0], bus.ACL_MOSI};
  assign csn_rise  = csn_q[1] & ~csn_q[2];
  assign csn_fall  = ~csn_q[1] & csn_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign byte_next = {shin_q[6:0], mosi_q[1]};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign ptr_inc   = ptr_q + ADDR_W'(1);
  assign addr_byte = byte_next[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    ptr_d       = ptr_q;
    wr_flag_d   = wr_flag_q;
    seen_rise_d = seen_rise_q;
    miso_d      = miso_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    regs_d      = regs_q;

    if (csn_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      miso_d      = 1'b0;
      done_d      = seen_rise_q;
      seen_rise_d = 1'b0;
    end else if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (csn_fall) begin
        state_d     = CMD;
        bit_cnt_d   = '0;
        seen_rise_d = 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        shin_d      = byte_next;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        seen_rise_d = 1'b1;
      end
      unique case (state_q)
        CMD: if (byte_done) begin
          if (byte_next == 8'h0A) begin
            state_d   = ADDR;
            wr_flag_d = 1'b1;
          end else if (byte_next == 8'h0B) begin
            state_d   = ADDR;
            wr_flag_d = 1'b0;
          end else begin
            state_d = IGNORE;
          end
        end
        ADDR: if (byte_done) begin
          ptr_d = addr_byte;
          if (wr_flag_q) begin
            state_d = WDATA;
          end else begin
            state_d = RDATA;
            shout_d = regs_q[addr_byte];
          end
        end
        WDATA: if (byte_done) begin
          if (ptr_q >= ADDR_W'(RO_TOP)) begin
            regs_d[ptr_q] = byte_next;
            wr_valid_d    = 1'b1;
            wr_addr_d     = ptr_q;
            wr_data_d     = byte_next;
          end
          ptr_d = ptr_inc;
        end
        RDATA: begin
          if (sclk_fall) begin
            miso_d  = shout_q[7];
            shout_d = {shout_q[6:0], 1'b0};
          end
          if (byte_done) begin
            ptr_d   = ptr_inc;
            shout_d = regs_q[ptr_inc];
          end
        end
        default: ;
      endcase
    end

    // Local write applied last so it overrides a same-cycle SPI commit.
    if (bus.loc_we) regs_d[bus.loc_addr] = bus.loc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csn_q       <= '0;
      sclk_q      <= '0;
      mosi_q      <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      ptr_q       <= '0;
      wr_flag_q   <= 1'b0;
      seen_rise_q <= 1'b0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      regs_q[0] <= 8'hAD;
      regs_q[1] <= 8'h1D;
      regs_q[2] <= 8'hF2;
      regs_q[3] <= 8'h01;
    end else begin
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      ptr_q       <= ptr_d;
      wr_flag_q   <= wr_flag_d;
      seen_rise_q <= seen_rise_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.ACL_MISO     = miso_q;
  assign bus.spi_wr_valid = wr_valid_q;
  assign bus.spi_wr_addr  = wr_addr_q;
  assign bus.spi_wr_data  = wr_data_q;
  assign bus.txn_done     = done_q;

endmodule
